// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display blocks: active-low hex font,
// all-off constants and the scanner's slot state type.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // seg[0]..seg[6] = a..g, 0 = segment lit
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Value/control inputs and multiplexed display pins of the 7-segment scanner.
interface seven_seg_scanner_if #(
    parameter int N4 = 4,
    parameter int N7 = 7
);
    logic [4*N4-1:0] value;
    logic            load;
    logic [N4-1:0]   dp_in;
    logic [N4-1:0]   blank;
    logic            lz_en;
    logic [N7-1:0]   seg;
    logic            dp;
    logic [N4-1:0]   an;

    modport master (
        output value, load, dp_in, blank, lz_en,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, dp_in, blank, lz_en,
        output seg, dp, an
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with blanking,
// leading-zero suppression, decimal points and an anti-ghosting gap slot.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int N4          = 4,
    parameter int N7          = 7,
    parameter int REFRESH_DIV = 100_000,
    parameter int CW          = 17
) (
    input  logic               clk,
    input  logic               btnU,
    seven_seg_scanner_if.slave bus
);

    localparam int IW = $clog2(N4);

    logic [CW-1:0]   presc;
    logic [IW-1:0]   idx;
    scan_state_t     state;
    logic            tick;

    logic [4*N4-1:0] sh_value;
    logic [N4-1:0]   sh_dp;
    logic [N4-1:0]   sh_blank;
    logic            sh_lz;

    logic [4*N4-1:0] upper;
    logic            zero_hi;
    logic            dark;
    logic [6:0]      font_seg;
    logic [N7-1:0]   seg_show;
    logic [N4-1:0]   an_show;
    logic            dp_show;

    logic [N7-1:0]   seg_q;
    logic [N4-1:0]   an_q;
    logic            dp_q;

    assign tick = (presc == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (bus.load) begin
            sh_value <= bus.value;
            sh_dp    <= bus.dp_in;
            sh_blank <= bus.blank;
            sh_lz    <= bus.lz_en;
        end
    end

    // Current digit sits in the low nibble; everything above it decides leading-zero darkness.
    assign upper   = sh_value >> {idx, 2'b00};
    assign zero_hi = ~|upper;
    assign dark    = sh_blank[idx] | (sh_lz & (idx != '0) & zero_hi);

    hex_to_seg7 u_dec (
        .nib (upper[3:0]),
        .seg (font_seg)
    );

    assign seg_show = dark ? N7'(SEG_OFF) : N7'(font_seg);
    assign an_show  = dark ? N4'(AN_OFF) : ~(N4'(1) << idx);
    assign dp_show  = ~(sh_dp[idx] & ~dark);

    // The tick edge loads the blank pattern, so GAP is the cycle the pins are dark
    // and the index has already moved on to the next digit.
    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            presc <= '0;
            idx   <= '0;
            state <= SHOW;
            seg_q <= N7'(SEG_OFF);
            an_q  <= N4'(AN_OFF);
            dp_q  <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= idx + 1'b1;
            case (state)
                SHOW: begin
                    if (tick) begin
                        state <= GAP;
                        seg_q <= N7'(SEG_OFF);
                        an_q  <= N4'(AN_OFF);
                        dp_q  <= 1'b1;
                    end else begin
                        seg_q <= seg_show;
                        an_q  <= an_show;
                        dp_q  <= dp_show;
                    end
                end
                GAP: begin
                    state <= SHOW;
                    seg_q <= seg_show;
                    an_q  <= an_show;
                    dp_q  <= dp_show;
                end
                default: state <= SHOW;
            endcase
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at REFRESH_DIV=4 (4-cycle digit slots).
module tb_seven_seg_scanner;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic [3:0]      blank;
        logic            lz_en;
        logic [3:0]      dark;
        logic [3:0][6:0] seg;
        logic [3:0]      dp_n;
    } vec_t;

    logic clk;
    logic btnU;
    int   n_cmp;
    int   n_err;
    vec_t vecs [7];

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .N4          (4),
        .N7          (7),
        .REFRESH_DIV (4),
        .CW          (2)
    ) dut (
        .clk  (clk),
        .btnU (btnU),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] bl,
                                input logic lz, input logic [3:0] dk, input logic [27:0] sg,
                                input logic [3:0] dpn);
        vec_t r;
        r.value = v;
        r.dp_in = dpi;
        r.blank = bl;
        r.lz_en = lz;
        r.dark  = dk;
        r.seg   = sg;
        r.dp_n  = dpn;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                         input logic exp_dp, input logic chk_seg);
        logic bad;
        n_cmp++;
        bad = (bus.an !== exp_an) || (bus.dp !== exp_dp) || (chk_seg && (bus.seg !== exp_seg));
        if (bad) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     name, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    task automatic check_off(input string name);
        check(name, 4'b1111, 7'h7F, 1'b1, 1'b1);
    endtask

    // Reset, release with load of v, then walk one full frame (edges 1..16).
    task automatic run_vector(input int k, input vec_t v);
        int slot;
        int pos;
        logic [3:0] an_e;
        btnU = 1'b1;
        step();
        bus.value = v.value;
        bus.dp_in = v.dp_in;
        bus.blank = v.blank;
        bus.lz_en = v.lz_en;
        bus.load  = 1'b1;
        btnU      = 1'b0;
        step();
        check($sformatf("v%0d_first_edge", k), 4'b1110, 7'h40, 1'b1, 1'b1);
        bus.load = 1'b0;
        for (int e = 2; e <= 16; e++) begin
            step();
            slot = (e - 1) / 4;
            pos  = (e - 1) % 4;
            if (pos == 3) begin
                check_off($sformatf("v%0d_gap_e%0d", k, e));
            end else begin
                an_e = v.dark[slot] ? 4'b1111 : ~(4'b0001 << slot);
                check($sformatf("v%0d_d%0d_e%0d", k, slot, e), an_e, v.seg[slot],
                      v.dp_n[slot], !v.dark[slot]);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        btnU      = 1'b1;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank = '0;
        bus.lz_en = 1'b0;
        bus.load  = 1'b0;

        //              value     dp_in    blank    lz    dark     seg d3..d0                      dp_n
        vecs[0] = mk(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
        vecs[1] = mk(16'h0070, 4'b0000, 4'b0000, 1'b1, 4'b1100, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111);
        vecs[2] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
        vecs[3] = mk(16'h8888, 4'b0011, 4'b0010, 1'b0, 4'b0010, {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1110);
        vecs[4] = mk(16'h0070, 4'b0000, 4'b0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111);
        vecs[5] = mk(16'hABCD, 4'b1000, 4'b0000, 1'b1, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0111);
        vecs[6] = mk(16'h0F00, 4'b1111, 4'b0001, 1'b1, 4'b1001, {7'h7F, 7'h0E, 7'h40, 7'h7F}, 4'b1001);

        // Reset held for three cycles: pins all off throughout.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_off($sformatf("reset_hold_%0d", i));
            step();
        end

        for (int k = 0; k < 7; k++) run_vector(k, vecs[k]);

        // Load coherence: inputs churn without load while digit 0 of 1234 shows.
        run_vector(7, vecs[0]);
        for (int e = 17; e <= 19; e++) begin
            bus.value = 16'($urandom);
            bus.dp_in = 4'($urandom);
            bus.blank = 4'($urandom);
            bus.lz_en = 1'($urandom);
            step();
            check($sformatf("no_load_e%0d", e), 4'b1110, 7'h19, 1'b1, 1'b1);
        end

        // Load on the tick cycle: gap unaffected, next digit shows the new nibble.
        bus.value = 16'h5678;
        bus.dp_in = 4'b0000;
        bus.blank = 4'b0000;
        bus.lz_en = 1'b0;
        bus.load  = 1'b1;
        step();
        check_off("tick_load_gap");
        bus.load = 1'b0;
        step();
        check("tick_load_next_digit", 4'b1101, 7'h78, 1'b1, 1'b1);
        step();
        check("tick_load_hold", 4'b1101, 7'h78, 1'b1, 1'b1);
        step();
        step();
        check_off("tick_load_gap2");
        step();
        check("d2_show_6", 4'b1011, 7'h02, 1'b1, 1'b1);

        // Mid-SHOW load: old value on the capture edge, new value one edge later.
        bus.value = 16'h0100;
        bus.load  = 1'b1;
        step();
        check("load_capture_edge", 4'b1011, 7'h02, 1'b1, 1'b1);
        bus.load = 1'b0;
        step();
        check("load_visible", 4'b1011, 7'h79, 1'b1, 1'b1);

        // Asynchronous reset during digit 2's slot.
        btnU = 1'b1;
        #1;
        check_off("async_reset_immediate");
        step();
        check_off("async_reset_held");
        btnU = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("resume_d0_e%0d", e), 4'b1110, 7'h40, 1'b1, 1'b1);
        end
        step();
        check_off("resume_gap");
        step();
        check("resume_d1", 4'b1101, 7'h40, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
